// File: rtl/net_pkg.sv
// Shared definitions for the network TX datapath: AXIS widths, beat layout and
// the store-and-forward FIFO write-side states.
package net_pkg;

  localparam int unsigned NET_DATA_WIDTH = 512;
  localparam int unsigned NET_KEEP_WIDTH = NET_DATA_WIDTH / 8;

  typedef struct packed {
    logic                      tlast;
    logic [NET_KEEP_WIDTH-1:0] tkeep;
    logic [NET_DATA_WIDTH-1:0] tdata;
  } axis_beat_t;

  typedef enum logic [0:0] {
    StPass,
    StDrop
  } tx_state_e;

endpackage

// File: rtl/net_tx_pkt_fifo_if.sv
// One AXI4-Stream link (tvalid/tready/tdata/tkeep/tlast) with source and sink views.
interface net_tx_pkt_fifo_if #(
  parameter int unsigned DATA_WIDTH = net_pkg::NET_DATA_WIDTH
);

  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/net_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module net_sdp_ram #(
  parameter int unsigned Width     = 32,
  parameter int unsigned AddrWidth = 6
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [Width-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [Width-1:0]     rd_data_o
);

  logic [Width-1:0] mem [2**AddrWidth];
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/net_tx_pkt_fifo.sv
// Store-and-forward frame FIFO ahead of the CMAC TX port: frames are released only once
// complete, so the MAC never sees a mid-frame gap; frames larger than the buffer are dropped.
module net_tx_pkt_fifo
  import net_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = NET_DATA_WIDTH,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  net_tx_pkt_fifo_if.slave         s_axis_tx,
  net_tx_pkt_fifo_if.master        m_axis_net_tx,
  output logic [31:0]              stat_drop_cnt,
  output logic [31:0]              stat_fwd_cnt
);

  localparam int unsigned KeepW  = DATA_WIDTH / 8;
  localparam int unsigned EntryW = DATA_WIDTH + KeepW + 1;
  localparam int unsigned PtrW   = DEPTH_LOG2 + 1;
  localparam logic [PtrW-1:0] DepthPtr = PtrW'(2**DEPTH_LOG2);

  tx_state_e         state_q, state_d;
  logic [PtrW-1:0]   wr_q, wr_d, commit_q, commit_d, rd_q;
  logic [31:0]       drop_q, drop_d, fwd_q, fwd_d;
  logic              full, wr_en, rd_en, pop;
  logic [2:0]        occ_nxt;
  logic [EntryW-1:0] ram_rdata, out_q, out_d, skid_q, skid_d;
  logic              ram_vld_q, out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;

  assign full = (wr_q - rd_q) == DepthPtr;

  // Write side: accept, commit on tlast, or discard a frame that cannot fit.
  always_comb begin
    state_d          = state_q;
    wr_d             = wr_q;
    commit_d         = commit_q;
    drop_d           = drop_q;
    wr_en            = 1'b0;
    s_axis_tx.tready = 1'b0;
    unique case (state_q)
      StPass: begin
        if (full && (rd_q == commit_q)) begin
          // Buffer holds only the current frame and is full: it can never complete.
          s_axis_tx.tready = 1'b1;
          if (s_axis_tx.tvalid) begin
            wr_d = commit_q;
            if (drop_q != '1) begin
              drop_d = drop_q + 32'd1;
            end
            if (!s_axis_tx.tlast) begin
              state_d = StDrop;
            end
          end
        end else if (!full) begin
          s_axis_tx.tready = 1'b1;
          if (s_axis_tx.tvalid) begin
            wr_en = 1'b1;
            wr_d  = wr_q + 1'b1;
            if (s_axis_tx.tlast) begin
              commit_d = wr_q + 1'b1;
            end
          end
        end
      end
      StDrop: begin
        s_axis_tx.tready = 1'b1;
        if (s_axis_tx.tvalid && s_axis_tx.tlast) begin
          state_d = StPass;
        end
      end
      default: state_d = StPass;
    endcase
  end

  net_sdp_ram #(
    .Width     (EntryW),
    .AddrWidth (DEPTH_LOG2)
  ) u_ram (
    .clk_i     (ap_clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_q[DEPTH_LOG2-1:0]),
    .wr_data_i ({s_axis_tx.tlast, s_axis_tx.tkeep, s_axis_tx.tdata}),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_q[DEPTH_LOG2-1:0]),
    .rd_data_o (ram_rdata)
  );

  // Issue a read only if the output + skid pair can absorb it when it lands.
  assign pop     = out_vld_q && m_axis_net_tx.tready;
  assign occ_nxt = 3'(out_vld_q) + 3'(skid_vld_q) + 3'(ram_vld_q) - 3'(pop);
  assign rd_en   = (rd_q != commit_q) && (occ_nxt <= 3'd1);

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (pop || !out_vld_q) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_d     = ram_rdata;
        skid_vld_d = ram_vld_q;
      end else begin
        out_vld_d = ram_vld_q;
        if (ram_vld_q) begin
          out_d = ram_rdata;
        end
      end
    end else if (ram_vld_q) begin
      skid_d     = ram_rdata;
      skid_vld_d = 1'b1;
    end
    fwd_d = fwd_q + 32'(pop && out_q[EntryW-1]);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= StPass;
      wr_q       <= '0;
      commit_q   <= '0;
      rd_q       <= '0;
      drop_q     <= '0;
      fwd_q      <= '0;
      ram_vld_q  <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      commit_q   <= commit_d;
      rd_q       <= rd_en ? rd_q + 1'b1 : rd_q;
      drop_q     <= drop_d;
      fwd_q      <= fwd_d;
      ram_vld_q  <= rd_en;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign m_axis_net_tx.tvalid = out_vld_q;
  assign m_axis_net_tx.tdata  = out_q[DATA_WIDTH-1:0];
  assign m_axis_net_tx.tkeep  = out_q[DATA_WIDTH +: KeepW];
  assign m_axis_net_tx.tlast  = out_q[EntryW-1];
  assign stat_drop_cnt        = drop_q;
  assign stat_fwd_cnt         = fwd_q;

endmodule

// File: tb/tb_net_tx_pkt_fifo.sv
// Randomized scoreboard bench for net_tx_pkt_fifo: frames that fit are expected in order,
// oversize frames are expected to vanish and be counted.
module tb_net_tx_pkt_fifo;
  import net_pkg::*;

  localparam int unsigned DepthLog2 = 6;
  localparam int Depth = 2**DepthLog2;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [31:0] stat_drop_cnt, stat_fwd_cnt;

  always #5 ap_clk = ~ap_clk;

  net_tx_pkt_fifo_if s_if ();
  net_tx_pkt_fifo_if m_if ();

  net_tx_pkt_fifo #(
    .DATA_WIDTH (NET_DATA_WIDTH),
    .DEPTH_LOG2 (DepthLog2)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .s_axis_tx     (s_if),
    .m_axis_net_tx (m_if),
    .stat_drop_cnt (stat_drop_cnt),
    .stat_fwd_cnt  (stat_fwd_cnt)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  axis_beat_t exp_q[$];
  int exp_fwd = 0;
  int exp_drop = 0;
  int rdy_mode = 0;  // 0: m_tready low, 1: high, 2: random
  int beats_out = 0;
  int rise_edge = -1;
  int stall_cycles = 0;
  int tlast_edge = 0;
  bit prev_mid = 1'b0;
  bit prev_tv = 1'b0;
  bit t3_done = 1'b0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  task automatic monitor();
    axis_beat_t e;
    forever begin
      @(negedge ap_clk);
      case (rdy_mode)
        0:       m_if.tready = 1'b0;
        1:       m_if.tready = 1'b1;
        default: m_if.tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (ap_rst) begin
        prev_mid = 1'b0;
        prev_tv  = 1'b0;
      end else begin
        if (prev_mid) chk("m_tvalid_gap", m_if.tvalid, 1);
        if (m_if.tvalid && !prev_tv) rise_edge = cyc;
        prev_tv  = m_if.tvalid;
        prev_mid = 1'b0;
        if (m_if.tvalid && m_if.tready) begin
          beats_out++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: actual=%0h required=none", m_if.tdata);
          end else begin
            e = exp_q.pop_front();
            chk("m_tdata", m_if.tdata, e.tdata);
            chk("m_tkeep", m_if.tkeep, e.tkeep);
            chk("m_tlast", m_if.tlast, e.tlast);
          end
          prev_mid = !m_if.tlast;
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is accepted.
  task automatic drive_beat(input axis_beat_t b);
    int waited = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = b.tdata;
    s_if.tkeep  = b.tkeep;
    s_if.tlast  = b.tlast;
    while (!s_if.tready) begin
      if (waited >= 3000) begin
        fail("s_tready_wait");
        s_if.tvalid = 1'b0;
        return;
      end
      @(negedge ap_clk);
      waited++;
      stall_cycles++;
    end
    @(negedge ap_clk);
    if (b.tlast) tlast_edge = cyc;
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len);
    axis_beat_t b;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < NET_DATA_WIDTH / 32; w++) b.tdata[w*32 +: 32] = $urandom;
      b.tkeep = (i == len - 1) ? {$urandom, $urandom} : '1;
      b.tlast = (i == len - 1);
      if (len <= Depth) exp_q.push_back(b);
      drive_beat(b);
    end
    if (len <= Depth) exp_fwd++;
    else exp_drop++;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge ap_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail("drain");
      exp_q.delete();
    end
    repeat (3) @(negedge ap_clk);
  endtask

  initial begin
    int n;
    int st;
    int base;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    fork
      monitor();
    join_none
    repeat (4) @(negedge ap_clk);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_drop_cnt", stat_drop_cnt, 0);
    chk("rst_fwd_cnt", stat_fwd_cnt, 0);
    chk("rst_s_tready", s_if.tready, 1);
    ap_rst = 1'b0;

    // 1: single 4-beat frame, latency and back-to-back output
    rdy_mode = 1;
    @(negedge ap_clk);
    rise_edge = -1;
    send_frame(4);
    chk("t1_no_early_tvalid", rise_edge, -1);
    wait_drain();
    chk("t1_latency_edge", rise_edge, tlast_edge + 2);
    chk("t1_fwd_cnt", stat_fwd_cnt, exp_fwd);

    // 2: random frame lengths, random m_tready
    rdy_mode = 2;
    for (int f = 0; f < 10; f++) send_frame($urandom_range(1, Depth));
    rdy_mode = 1;
    wait_drain();
    chk("t2_fwd_cnt", stat_fwd_cnt, exp_fwd);
    chk("t2_drop_cnt", stat_drop_cnt, exp_drop);

    // 3: fill with m_tready low, then release
    rdy_mode = 0;
    fork
      begin
        for (int f = 0; f < 12; f++) send_frame(6);
        t3_done = 1'b1;
      end
    join_none
    n = 0;
    do begin
      @(negedge ap_clk);
      #2;
      n++;
    end while (!(s_if.tvalid && !s_if.tready) && n < 2000);
    if (n >= 2000) fail("t3_fill");
    chk("t3_committed_present", m_if.tvalid, 1);
    repeat (3) begin
      @(negedge ap_clk);
      #2;
      chk("t3_backpressure", s_if.tready, 0);
    end
    @(posedge ap_clk);
    #1;
    rdy_mode = 1;
    @(negedge ap_clk);
    #2;
    chk("t3_full_before_read", s_if.tready, 0);
    @(negedge ap_clk);
    #2;
    chk("t3_tready_after_read", s_if.tready, 1);
    n = 0;
    while (!t3_done && n < 5000) begin
      @(negedge ap_clk);
      n++;
    end
    if (!t3_done) fail("t3_send");
    wait_drain();
    chk("t3_fwd_cnt", stat_fwd_cnt, exp_fwd);

    // 4: 70-beat frame dropped without backpressure, 3-beat frame passes
    rdy_mode = 1;
    st = stall_cycles;
    send_frame(70);
    chk("t4_no_stall", stall_cycles - st, 0);
    send_frame(3);
    wait_drain();
    chk("t4_drop_cnt", stat_drop_cnt, exp_drop);
    chk("t4_fwd_cnt", stat_fwd_cnt, exp_fwd);

    // 5: exactly Depth beats fits with m_tready low; Depth+1 is dropped
    rdy_mode = 0;
    st = stall_cycles;
    send_frame(Depth);
    chk("t5_fit_no_stall", stall_cycles - st, 0);
    repeat (3) @(negedge ap_clk);
    chk("t5_fit_no_drop", stat_drop_cnt, exp_drop);
    rdy_mode = 1;
    wait_drain();
    chk("t5_fit_fwd_cnt", stat_fwd_cnt, exp_fwd);
    send_frame(Depth + 1);
    repeat (3) @(negedge ap_clk);
    chk("t5_over_drop_cnt", stat_drop_cnt, exp_drop);
    chk("t5_over_nothing_out", exp_q.size(), 0);

    // 6: reset while beat 3 of a 6-beat frame is presented
    base = beats_out;
    send_frame(6);
    n = 0;
    do begin
      @(posedge ap_clk);
      #1;
      n++;
    end while (beats_out != base + 2 && n < 200);
    if (n >= 200) fail("t6_reach_beat3");
    ap_rst = 1'b1;
    @(negedge ap_clk);
    @(negedge ap_clk);
    chk("t6_rst_m_tvalid", m_if.tvalid, 0);
    chk("t6_rst_drop_cnt", stat_drop_cnt, 0);
    chk("t6_rst_fwd_cnt", stat_fwd_cnt, 0);
    exp_q.delete();
    exp_fwd  = 0;
    exp_drop = 0;
    ap_rst   = 1'b0;
    repeat (2) @(negedge ap_clk);
    send_frame(5);
    wait_drain();
    chk("t6_fresh_fwd_cnt", stat_fwd_cnt, exp_fwd);
    chk("t6_fresh_drop_cnt", stat_drop_cnt, exp_drop);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
